// File: rtl/activation_stream_unit.sv
// activation_stream_unit
//   Streams a feature map of TOTAL = DATA_HEIGHT*DATA_WIDTH*DATA_CHANNELS
//   signed elements, PARALLEL_FACTOR lanes per beat. Each element passes
//   through a configurable activation (bypass / ReLU / leaky ReLU / clipped
//   ReLU) and is then requantised by an arithmetic right shift with signed
//   saturation to BITWIDTH bits. The datapath is two stages deep and
//   advances under one shared enable.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cfg_mode, cfg_clip  activation mode and clip ceiling, latched on the
//                       first beat of each frame
//   s_valid/s_ready     input beat handshake, s_data = PF lanes of 2*BITWIDTH
//   m_valid/m_ready     output beat handshake, m_data = PF lanes of BITWIDTH
//   m_last              marks the final output beat of a frame
//   frame_done          one-cycle pulse after the final output beat transfers
//   busy                a frame is in flight
module activation_stream_unit #(
    parameter int BITWIDTH        = 16,
    parameter int DATA_WIDTH      = 6,
    parameter int DATA_HEIGHT     = 6,
    parameter int DATA_CHANNELS   = 8,
    parameter int PARALLEL_FACTOR = 4,
    parameter int OUT_SHIFT       = 8,
    parameter int LEAK_SHIFT      = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [1:0]                             cfg_mode,
    input  logic [BITWIDTH-1:0]                    cfg_clip,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic [PARALLEL_FACTOR*2*BITWIDTH-1:0]  s_data,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic [PARALLEL_FACTOR*BITWIDTH-1:0]    m_data,
    output logic                                   m_last,
    output logic                                   frame_done,
    output logic                                   busy
);
    localparam int IW    = 2 * BITWIDTH;
    localparam int PF    = PARALLEL_FACTOR;
    localparam int TOTAL = DATA_HEIGHT * DATA_WIDTH * DATA_CHANNELS;
    localparam int BEATS = (TOTAL + PF - 1) / PF;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    // Stage-1 activation on one lane.
    function automatic logic signed [IW-1:0] activate(
        input logic signed [IW-1:0] x,
        input logic [1:0]           mode,
        input logic [BITWIDTH-1:0]  clip
    );
        logic signed [IW-1:0] ceil_v;
        ceil_v = $signed({{BITWIDTH{1'b0}}, clip});
        case (mode)
            2'b00:   activate = x;
            2'b01:   activate = x[IW-1] ? '0 : x;
            2'b10:   activate = x[IW-1] ? (x >>> LEAK_SHIFT) : x;
            default: activate = x[IW-1] ? '0 : ((x > ceil_v) ? ceil_v : x);
        endcase
    endfunction

    // Stage-2 floor shift followed by saturation to signed BITWIDTH.
    function automatic logic [BITWIDTH-1:0] requant(input logic signed [IW-1:0] y);
        logic signed [IW-1:0] z;
        logic signed [IW-1:0] zmax;
        logic signed [IW-1:0] zmin;
        z    = y >>> OUT_SHIFT;
        zmax = $signed({{(BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}});
        zmin = $signed({{(BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}});
        if (z > zmax)      requant = {1'b0, {(BITWIDTH-1){1'b1}}};
        else if (z < zmin) requant = {1'b1, {(BITWIDTH-1){1'b0}}};
        else               requant = z[BITWIDTH-1:0];
    endfunction

    state_t                   state_q;
    logic [CNT_W-1:0]         beat_q;
    logic [1:0]               mode_q;
    logic [BITWIDTH-1:0]      clip_q;
    logic                     vld_p1_q, last_p1_q;
    logic [PF*IW-1:0]         y_p1_q;
    logic                     m_valid_q, m_last_q;
    logic [PF*BITWIDTH-1:0]   m_data_q;
    logic                     frame_done_q, busy_q;

    logic                     en, accept, first_beat, final_beat, out_last_xfer;
    logic [1:0]               mode_eff;
    logic [BITWIDTH-1:0]      clip_eff;
    logic [PF*IW-1:0]         y_d;
    logic [PF*BITWIDTH-1:0]   m_data_d;

    always_comb begin
        en            = !m_valid_q || m_ready;
        s_ready       = en && !rst;
        accept        = s_valid && s_ready;
        first_beat    = (state_q == IDLE);
        final_beat    = (beat_q == LAST_BEAT);
        out_last_xfer = m_valid_q && m_ready && m_last_q;
        // The first beat of a frame uses the live config, since the latch
        // only captures it on this same edge.
        mode_eff      = first_beat ? cfg_mode : mode_q;
        clip_eff      = first_beat ? cfg_clip : clip_q;
        y_d           = '0;
        for (int p = 0; p < PF; p++) begin
            // Lanes past the end of the frame on the final beat are padding.
            if (!(final_beat && (((BEATS - 1) * PF + p) >= TOTAL)))
                y_d[p*IW +: IW] = activate(s_data[p*IW +: IW], mode_eff, clip_eff);
        end
        m_data_d = '0;
        for (int p = 0; p < PF; p++)
            m_data_d[p*BITWIDTH +: BITWIDTH] = requant(y_p1_q[p*IW +: IW]);
    end

    // Frame sequencer: beat counter and per-frame configuration latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            mode_q  <= 2'b00;
            clip_q  <= '0;
        end else if (accept) begin
            if (first_beat) begin
                mode_q <= cfg_mode;
                clip_q <= cfg_clip;
            end
            if (final_beat) begin
                state_q <= IDLE;
                beat_q  <= '0;
            end else begin
                state_q <= RUN;
                beat_q  <= beat_q + CNT_W'(1);
            end
        end
    end

    // Stage 1 boundary: activated lanes.
    always_ff @(posedge clk) begin
        if (en) y_p1_q <= y_d;
    end

    // Stage 1 control and stage 2 boundary: requantised output beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            last_p1_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else if (en) begin
            vld_p1_q  <= accept;
            last_p1_q <= accept && final_beat;
            m_valid_q <= vld_p1_q;
            m_last_q  <= last_p1_q;
            m_data_q  <= m_data_d;
        end
    end

    // busy stays up across back-to-back frames: it only drops when the last
    // output leaves and no newer frame has started.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frame_done_q <= out_last_xfer;
            if (accept)
                busy_q <= 1'b1;
            else if (out_last_xfer && state_q == IDLE)
                busy_q <= 1'b0;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign m_data     = m_data_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
endmodule
